// File: rtl/apb2axi_pkg.sv
// Shared APB2AXI definitions: default widths, AXI response encodings,
// the completion-entry layout and a response classification helper.
package apb2axi_pkg;

  localparam int ID_W_DEF   = 4;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                  is_wr;
    logic [ID_W_DEF-1:0]   id;
    logic [DATA_W_DEF-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } cpl_entry_t;

  // SLVERR and DECERR both carry resp[1]=1.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/cpl_out_reg.sv
// Single-entry valid/ready output register. The caller only asserts load
// when the slot is free (empty, or draining this cycle).
module cpl_out_reg #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/completion_arbiter.sv
// Merges AXI B (write) and R (read) completions into one Completion FIFO stream.
// Optional APB2AXI_CPL_ERR_CNT_EN adds a saturating 16-bit error-response counter.
//
// Handshakes: a transfer happens on a rising edge where valid=1 and ready=1.
// Source readys are combinational grants, never both high, and only high when
// the output slot is free; cpl_valid/cpl_* hold steady while cpl_ready=0.
module completion_arbiter
  import apb2axi_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              wr_cpl_valid,
  output logic              wr_cpl_ready,
  input  logic [ID_W-1:0]   wr_cpl_id,
  input  logic [1:0]        wr_cpl_resp,
  input  logic              rd_cpl_valid,
  output logic              rd_cpl_ready,
  input  logic [ID_W-1:0]   rd_cpl_id,
  input  logic [DATA_W-1:0] rd_cpl_data,
  input  logic [1:0]        rd_cpl_resp,
  input  logic              rd_cpl_last,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic              cpl_is_wr,
  output logic [ID_W-1:0]   cpl_id,
  output logic [DATA_W-1:0] cpl_data,
  output logic [1:0]        cpl_resp,
  output logic              cpl_last,
  output logic              dbg_state
`ifdef APB2AXI_CPL_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int ENT_W = 1 + ID_W + DATA_W + 2 + 1;
  localparam logic RR_WR = 1'b0;
  localparam logic RR_RD = 1'b1;

  typedef enum logic {ARB = 1'b0, RD_LOCK = 1'b1} state_t;

  state_t           state;
  logic             rr_last;
  logic             slot_free;
  logic             wr_gnt;
  logic             rd_gnt;
  logic             load;
  logic [ENT_W-1:0] ent_d;
  logic [ENT_W-1:0] ent_q;

  assign slot_free = !cpl_valid || cpl_ready;

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!rst && slot_free) begin
      if (state == RD_LOCK) begin
        rd_gnt = rd_cpl_valid;
      end else if (rd_cpl_valid && wr_cpl_valid) begin
        if (rr_last == RR_WR) rd_gnt = 1'b1;
        else                  wr_gnt = 1'b1;
      end else begin
        rd_gnt = rd_cpl_valid;
        wr_gnt = wr_cpl_valid;
      end
    end
  end

  assign wr_cpl_ready = wr_gnt;
  assign rd_cpl_ready = rd_gnt;
  assign load         = wr_gnt || rd_gnt;

  // Write completions carry no data and always close their "burst".
  assign ent_d = wr_gnt ? {1'b1, wr_cpl_id, {DATA_W{1'b0}}, wr_cpl_resp, 1'b1}
                        : {1'b0, rd_cpl_id, rd_cpl_data, rd_cpl_resp, rd_cpl_last};

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      rr_last <= RR_WR;
    end else begin
      if (wr_gnt) rr_last <= RR_WR;
      if (rd_gnt) begin
        if (rd_cpl_last) begin
          state   <= ARB;
          rr_last <= RR_RD;
        end else begin
          state <= RD_LOCK;
        end
      end
    end
  end

  assign dbg_state = (state == RD_LOCK);

  cpl_out_reg #(.W(ENT_W)) u_out (
    .aclk  (aclk),
    .rst   (rst),
    .load  (load),
    .din   (ent_d),
    .ready (cpl_ready),
    .valid (cpl_valid),
    .dout  (ent_q)
  );

  assign {cpl_is_wr, cpl_id, cpl_data, cpl_resp, cpl_last} = ent_q;

`ifdef APB2AXI_CPL_ERR_CNT_EN
  logic [1:0] gnt_resp;
  assign gnt_resp = wr_gnt ? wr_cpl_resp : rd_cpl_resp;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (load && resp_is_err(gnt_resp) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_completion_arbiter.sv
// Directed bench for completion_arbiter: hand-ordered expected entries in a
// queue, popped by an independent output monitor; plus direct signal checks.
module tb_completion_arbiter;
  import apb2axi_pkg::*;

  localparam int IW = ID_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int EW = $bits(cpl_entry_t);

  logic          aclk;
  logic          rst;
  logic          wr_cpl_valid, wr_cpl_ready;
  logic [IW-1:0] wr_cpl_id;
  logic [1:0]    wr_cpl_resp;
  logic          rd_cpl_valid, rd_cpl_ready;
  logic [IW-1:0] rd_cpl_id;
  logic [DW-1:0] rd_cpl_data;
  logic [1:0]    rd_cpl_resp;
  logic          rd_cpl_last;
  logic          cpl_valid, cpl_ready;
  logic          cpl_is_wr;
  logic [IW-1:0] cpl_id;
  logic [DW-1:0] cpl_data;
  logic [1:0]    cpl_resp;
  logic          cpl_last;
  logic          dbg_state;
`ifdef APB2AXI_CPL_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  completion_arbiter dut (
    .aclk         (aclk),
    .rst          (rst),
    .wr_cpl_valid (wr_cpl_valid),
    .wr_cpl_ready (wr_cpl_ready),
    .wr_cpl_id    (wr_cpl_id),
    .wr_cpl_resp  (wr_cpl_resp),
    .rd_cpl_valid (rd_cpl_valid),
    .rd_cpl_ready (rd_cpl_ready),
    .rd_cpl_id    (rd_cpl_id),
    .rd_cpl_data  (rd_cpl_data),
    .rd_cpl_resp  (rd_cpl_resp),
    .rd_cpl_last  (rd_cpl_last),
    .cpl_valid    (cpl_valid),
    .cpl_ready    (cpl_ready),
    .cpl_is_wr    (cpl_is_wr),
    .cpl_id       (cpl_id),
    .cpl_data     (cpl_data),
    .cpl_resp     (cpl_resp),
    .cpl_last     (cpl_last),
    .dbg_state    (dbg_state)
`ifdef APB2AXI_CPL_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  // Clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Driver and checking helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_wr(input logic [IW-1:0] id, input logic [1:0] resp);
    exp_q.push_back({1'b1, id, {DW{1'b0}}, resp, 1'b1});
  endtask

  task automatic push_rd(input logic [IW-1:0] id, input logic [DW-1:0] data,
                         input logic [1:0] resp, input logic last);
    exp_q.push_back({1'b0, id, data, resp, last});
  endtask

  task automatic drive_wr(input logic v, input logic [IW-1:0] id, input logic [1:0] resp);
    wr_cpl_valid = v;
    wr_cpl_id    = id;
    wr_cpl_resp  = resp;
  endtask

  task automatic drive_rd(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] data,
                          input logic last);
    rd_cpl_valid = v;
    rd_cpl_id    = id;
    rd_cpl_data  = data;
    rd_cpl_resp  = RESP_OKAY;
    rd_cpl_last  = last;
  endtask

  task automatic idle(input int n);
    wr_cpl_valid = 1'b0;
    rd_cpl_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Output monitor / scoreboard: samples 1 time unit before each rising edge
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    forever begin
      @(negedge aclk);
      #4;
      if (cpl_valid && cpl_ready) begin
        got = {cpl_is_wr, cpl_id, cpl_data, cpl_resp, cpl_last};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry actual=%0h required=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL entry_order actual=%0h required=%0h", got, exp);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst       = 1'b1;
    cpl_ready = 1'b0;
    drive_wr(1'b0, '0, RESP_OKAY);
    drive_rd(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge aclk);
    #1;

    // Reset state: no grants even with both sources valid
    wr_cpl_valid = 1'b1;
    rd_cpl_valid = 1'b1;
    cpl_ready    = 1'b1;
    #1;
    check("rst_wr_ready", wr_cpl_ready, 0);
    check("rst_rd_ready", rd_cpl_ready, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_fields", {cpl_is_wr, cpl_id, cpl_data, cpl_resp, cpl_last}, 0);
    check("rst_state", dbg_state, 0);
    wr_cpl_valid = 1'b0;
    rd_cpl_valid = 1'b0;
    #1 rst = 1'b0;
    tick();

    // Single write completion, latency 1
    drive_wr(1'b1, 4'd3, RESP_OKAY);
    #1;
    check("wr_only_grant", wr_cpl_ready, 1);
    check("wr_only_no_rd", rd_cpl_ready, 0);
    push_wr(4'd3, RESP_OKAY);
    tick();
    wr_cpl_valid = 1'b0;
    #1;
    check("wr_only_out_valid", cpl_valid, 1);
    check("wr_only_out_fields", {cpl_is_wr, cpl_id, cpl_data, cpl_last}, {1'b1, 4'd3, 32'h0, 1'b1});
    tick();
    check("wr_only_drained", cpl_valid, 0);

    // Both valid, single-beat reads: rd, wr, rd, wr
    push_rd(4'd1, 32'h11, RESP_OKAY, 1'b1);
    push_wr(4'd7, RESP_OKAY);
    push_rd(4'd2, 32'h22, RESP_OKAY, 1'b1);
    push_wr(4'd8, RESP_EXOKAY);
    drive_rd(1'b1, 4'd1, 32'h11, 1'b1);
    drive_wr(1'b1, 4'd7, RESP_OKAY);
    #1;
    check("rr_c0_rd", {rd_cpl_ready, wr_cpl_ready}, 2'b10);
    tick();
    drive_rd(1'b1, 4'd2, 32'h22, 1'b1);
    #1;
    check("rr_c1_wr", {rd_cpl_ready, wr_cpl_ready}, 2'b01);
    tick();
    drive_wr(1'b1, 4'd8, RESP_EXOKAY);
    #1;
    check("rr_c2_rd", {rd_cpl_ready, wr_cpl_ready}, 2'b10);
    check("rr_c2_streaming", cpl_valid, 1);
    tick();
    rd_cpl_valid = 1'b0;
    #1;
    check("rr_c3_wr", {rd_cpl_ready, wr_cpl_ready}, 2'b01);
    tick();
    idle(2);

    // 4-beat read burst locks out a write pending from beat 2
    push_rd(4'd5, 32'hA0, RESP_OKAY, 1'b0);
    push_rd(4'd5, 32'hA1, RESP_OKAY, 1'b0);
    push_rd(4'd5, 32'hA2, RESP_OKAY, 1'b0);
    push_rd(4'd5, 32'hA3, RESP_OKAY, 1'b1);
    push_wr(4'd9, RESP_OKAY);
    drive_rd(1'b1, 4'd5, 32'hA0, 1'b0);
    #1;
    check("burst_b1_grant", rd_cpl_ready, 1);
    tick();
    check("burst_locked", dbg_state, 1);
    drive_rd(1'b1, 4'd5, 32'hA1, 1'b0);
    drive_wr(1'b1, 4'd9, RESP_OKAY);
    #1;
    check("burst_b2_grants", {rd_cpl_ready, wr_cpl_ready}, 2'b10);
    tick();
    drive_rd(1'b1, 4'd5, 32'hA2, 1'b0);
    #1;
    check("burst_b3_grants", {rd_cpl_ready, wr_cpl_ready}, 2'b10);
    tick();
    drive_rd(1'b1, 4'd5, 32'hA3, 1'b1);
    #1;
    check("burst_b4_grants", {rd_cpl_ready, wr_cpl_ready}, 2'b10);
    tick();
    rd_cpl_valid = 1'b0;
    #1;
    check("burst_unlocked", dbg_state, 0);
    check("burst_then_wr", wr_cpl_ready, 1);
    tick();
    idle(2);

    // Back-pressure: entry held stable, no grants, then drain + reload
    cpl_ready = 1'b0;
    drive_wr(1'b1, 4'd4, RESP_SLVERR);
    #1;
    check("bp_load_grant", wr_cpl_ready, 1);
    push_wr(4'd4, RESP_SLVERR);
    push_rd(4'd2, 32'h55, RESP_OKAY, 1'b1);
    push_wr(4'd6, RESP_OKAY);
    tick();
    drive_wr(1'b1, 4'd6, RESP_OKAY);
    drive_rd(1'b1, 4'd2, 32'h55, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_no_grant", {rd_cpl_ready, wr_cpl_ready}, 2'b00);
      check("bp_held_valid", cpl_valid, 1);
      check("bp_held_entry", {cpl_is_wr, cpl_id, cpl_data, cpl_resp, cpl_last},
            {1'b1, 4'd4, 32'h0, RESP_SLVERR, 1'b1});
      tick();
    end
    cpl_ready = 1'b1;
    #1;
    check("bp_release_grant", {rd_cpl_ready, wr_cpl_ready}, 2'b10);
    tick();
    rd_cpl_valid = 1'b0;
    #1;
    check("bp_reloaded", {cpl_valid, cpl_is_wr, cpl_id}, {1'b1, 1'b0, 4'd2});
    check("bp_next_wr", wr_cpl_ready, 1);
    tick();
    idle(2);

    // Reset in the middle of a read burst
    push_rd(4'd5, 32'hB0, RESP_OKAY, 1'b0);
    drive_rd(1'b1, 4'd5, 32'hB0, 1'b0);
    #1;
    check("mid_b1_grant", rd_cpl_ready, 1);
    tick();
    drive_rd(1'b1, 4'd5, 32'hB1, 1'b0);
    tick();
    rd_cpl_valid = 1'b0;
    drive_wr(1'b1, 4'hC, RESP_OKAY);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", cpl_valid, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_ready", wr_cpl_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_after_wr_grant", wr_cpl_ready, 1);
    push_wr(4'hC, RESP_OKAY);
    tick();
    idle(3);

`ifdef APB2AXI_CPL_ERR_CNT_EN
    // Error counter: 3 SLVERR + 2 DECERR + 4 OKAY, then saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("err_cnt_reset", err_cnt, 0);
    begin
      logic [1:0] resps [9];
      resps = '{RESP_SLVERR, RESP_SLVERR, RESP_SLVERR, RESP_DECERR, RESP_DECERR,
                RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY};
      for (int i = 0; i < 9; i++) begin
        drive_wr(1'b1, 4'(i), resps[i]);
        push_wr(4'(i), resps[i]);
        tick();
      end
    end
    idle(1);
    check("err_cnt_five", err_cnt, 5);
    for (int i = 0; i < 65531; i++) begin
      drive_wr(1'b1, 4'd1, RESP_SLVERR);
      push_wr(4'd1, RESP_SLVERR);
      tick();
    end
    idle(2);
    check("err_cnt_saturated", err_cnt, 16'hFFFF);
`endif

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
